// File: rtl/button_event_conditioner.sv
// button_event_conditioner
//   Front-end for the two handlebar buttons. Each raw active-low pin is
//   synchronised, debounced and classified into single-cycle pulses:
//   short press (on release), long press (after LONG_CYCLES of hold) and
//   a both-buttons chord. Purely HCLK-domain, no bus interface.
// Ports
//   HCLK, HRESETn          clock, async active-low reset
//   nMode, nTrip           raw button pins, asynchronous, 0 = pressed
//   mode_level, trip_level debounced state, 1 = pressed
//   mode_press, trip_press short-press pulse, fires after release
//   mode_long, trip_long   long-hold pulse
//   both_press             chord pulse

// btn_chan: one button's synchroniser, debouncer and press classifier.
//   n_pin_i      raw pin, 0 = pressed
//   chord_fire_i chord detected this cycle; forces SUPPRESS
//   level_o      debounced level, 1 = pressed
//   press_o      short-press pulse
//   long_o       long-press pulse
//   supp_o       channel is in SUPPRESS
module btn_chan #(
  parameter int DEBOUNCE_CYCLES = 820,
  parameter int LONG_CYCLES     = 16384,
  parameter int CNT_W           = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic n_pin_i,
  input  logic chord_fire_i,
  output logic level_o,
  output logic press_o,
  output logic long_o,
  output logic supp_o
);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG, SUPPRESS} state_t;

  logic             s1_q, s2_q;
  logic             stable_q;
  logic [CNT_W-1:0] db_cnt_q;
  logic [CNT_W-1:0] hold_q;
  logic             press_q, long_q;
  state_t           state_q;
  logic             sync_pressed;

  assign sync_pressed = ~s2_q;

  // Synchroniser + debouncer. Stable flips on the DEBOUNCE_CYCLES-th
  // consecutive disagreeing cycle; any agreement restarts the count.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      s1_q <= n_pin_i;
      s2_q <= s1_q;
      if (sync_pressed != stable_q) begin
        if (db_cnt_q == DEB_MAX) begin
          stable_q <= ~stable_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Press classifier. The chord overrides every other transition so a
  // coincident long threshold never produces its own pulse.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      hold_q  <= '0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      long_q  <= 1'b0;
      if (chord_fire_i) begin
        state_q <= SUPPRESS;
      end else begin
        case (state_q)
          IDLE: if (stable_q) begin
            state_q <= HELD;
            hold_q  <= '0;
          end
          HELD: if (!stable_q) begin
            state_q <= IDLE;
            press_q <= 1'b1;
          end else if (hold_q == LONG_MAX) begin
            state_q <= LONG;
            long_q  <= 1'b1;
          end else begin
            // never passes LONG_MAX, so the counter saturates by construction
            hold_q <= hold_q + 1'b1;
          end
          LONG:     if (!stable_q) state_q <= IDLE;
          SUPPRESS: if (!stable_q) state_q <= IDLE;
          default:  state_q <= IDLE;
        endcase
      end
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;
  assign long_o  = long_q;
  assign supp_o  = (state_q == SUPPRESS);
endmodule

module button_event_conditioner #(
  parameter int DEBOUNCE_CYCLES = 820,
  parameter int CHORD_CYCLES    = 328,
  parameter int LONG_CYCLES     = 16384,
  parameter int CNT_W           = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic nMode,
  input  logic nTrip,
  output logic mode_level,
  output logic trip_level,
  output logic mode_press,
  output logic trip_press,
  output logic mode_long,
  output logic trip_long,
  output logic both_press
);
  localparam int NUM_BTN = 2;  // index 0 = Mode, 1 = Trip
  localparam logic [CNT_W-1:0] CHORD_MAX = CNT_W'(CHORD_CYCLES - 1);

  logic [NUM_BTN-1:0] n_pin, lvl, press, lng, supp;
  logic [CNT_W-1:0]   chord_cnt_q;
  logic               both_q;
  logic               chord_arm, chord_fire;

  assign n_pin = {nTrip, nMode};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .n_pin_i     (n_pin[i]),
      .chord_fire_i(chord_fire),
      .level_o     (lvl[i]),
      .press_o     (press[i]),
      .long_o      (lng[i]),
      .supp_o      (supp[i])
    );
  end

  // Gating on SUPPRESS keeps the chord from re-firing until both buttons
  // have been released back to IDLE.
  assign chord_arm  = (&lvl) && ~(|supp);
  assign chord_fire = chord_arm && (chord_cnt_q == CHORD_MAX);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      chord_cnt_q <= '0;
      both_q      <= 1'b0;
    end else begin
      both_q <= chord_fire;
      if (chord_arm && !chord_fire) chord_cnt_q <= chord_cnt_q + 1'b1;
      else                          chord_cnt_q <= '0;
    end
  end

  assign mode_level = lvl[0];
  assign trip_level = lvl[1];
  assign mode_press = press[0];
  assign trip_press = press[1];
  assign mode_long  = lng[0];
  assign trip_long  = lng[1];
  assign both_press = both_q;
endmodule

// File: tb/tb_button_event_conditioner.sv
module tb_button_event_conditioner;
  localparam int DEB = 4, CHORD = 8, LONGC = 20;

  logic HCLK = 1'b0;
  logic HRESETn, nMode, nTrip;
  logic mode_level, trip_level, mode_press, trip_press, mode_long, trip_long, both_press;

  button_event_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .CHORD_CYCLES(CHORD), .LONG_CYCLES(LONGC), .CNT_W(16)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .nMode(nMode), .nTrip(nTrip),
    .mode_level(mode_level), .trip_level(trip_level),
    .mode_press(mode_press), .trip_press(trip_press),
    .mode_long(mode_long), .trip_long(trip_long), .both_press(both_press)
  );

  always #5 HCLK = ~HCLK;

  int nvec = 0, nerr = 0, cyc = 0;

  // Reference model, event-level: pressed-form pin history, a window of the
  // last DEB synced samples, the length of the current held run, and
  // chord/suppress bookkeeping.
  bit m_s1[2], m_s2[2], m_stable[2], m_sup[2];
  bit m_win[2][DEB];
  int m_run[2], m_chord;
  bit e_lvl[2], e_press[2], e_long[2], e_both;

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_stable[b] = 0; m_sup[b] = 0; m_run[b] = 0;
      e_lvl[b] = 0; e_press[b] = 0; e_long[b] = 0;
      for (int i = 0; i < DEB; i++) m_win[b][i] = 0;
    end
    m_chord = 0; e_both = 0;
  endtask

  task automatic model_step(input bit pm, input bit pt);
    bit lp[2];
    bit all_diff;
    lp[0] = m_stable[0]; lp[1] = m_stable[1];
    e_both = 0;
    if (lp[0] && lp[1] && !m_sup[0] && !m_sup[1]) begin
      m_chord++;
      if (m_chord == CHORD) begin
        e_both = 1; m_sup[0] = 1; m_sup[1] = 1; m_chord = 0;
      end
    end else m_chord = 0;
    for (int b = 0; b < 2; b++) begin
      e_press[b] = 0; e_long[b] = 0;
      if (lp[b]) begin
        m_run[b]++;
        if (m_run[b] == LONGC + 1 && !m_sup[b]) e_long[b] = 1;
      end else begin
        if (m_run[b] > 0 && m_run[b] <= LONGC && !m_sup[b]) e_press[b] = 1;
        m_run[b] = 0; m_sup[b] = 0;
      end
      for (int i = DEB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
      m_win[b][0] = m_s2[b];
      all_diff = 1;
      for (int i = 0; i < DEB; i++) if (m_win[b][i] == m_stable[b]) all_diff = 0;
      if (all_diff) m_stable[b] = ~m_stable[b];
      e_lvl[b] = m_stable[b];
      m_s2[b] = m_s1[b];
    end
    m_s1[0] = pm; m_s1[1] = pt;
  endtask

  int c_mp, c_tp, c_ml, c_tl, c_bp;

  task automatic check_out();
    logic [6:0] got, exp;
    got = {mode_level, trip_level, mode_press, trip_press, mode_long, trip_long, both_press};
    exp = {e_lvl[0], e_lvl[1], e_press[0], e_press[1], e_long[0], e_long[1], e_both};
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL cyc%0d outputs{ml,tl,mp,tp,mL,tL,bp} got=%b exp=%b", cyc, got, exp);
    end
  endtask

  // One clock: drive at negedge, model on posedge, compare at next negedge.
  task automatic step(input bit nm, input bit nt);
    nMode = nm; nTrip = nt;
    @(posedge HCLK);
    model_step(~nm, ~nt);
    @(negedge HCLK);
    cyc++;
    check_out();
    c_mp += int'(mode_press); c_tp += int'(trip_press);
    c_ml += int'(mode_long);  c_tl += int'(trip_long); c_bp += int'(both_press);
  endtask

  typedef struct {
    bit nm, nt; int cycles;
    int mp, tp, ml, tl, bp;
    bit lm, lt;
  } phase_t;

  function automatic phase_t ph(bit nm, bit nt, int n, int mp, int tp, int ml, int tl, int bp,
                                bit lm, bit lt);
    phase_t p;
    p.nm = nm; p.nt = nt; p.cycles = n;
    p.mp = mp; p.tp = tp; p.ml = ml; p.tl = tl; p.bp = bp; p.lm = lm; p.lt = lt;
    return p;
  endfunction

  phase_t tbl[$];

  task automatic run_phase(input int idx, input phase_t p);
    c_mp = 0; c_tp = 0; c_ml = 0; c_tl = 0; c_bp = 0;
    for (int k = 0; k < p.cycles; k++) step(p.nm, p.nt);
    nvec++;
    if (c_mp != p.mp || c_tp != p.tp || c_ml != p.ml || c_tl != p.tl || c_bp != p.bp ||
        mode_level !== p.lm || trip_level !== p.lt) begin
      nerr++;
      $display("FAIL phase%0d counts mp/tp/ml/tl/bp lvl got=%0d/%0d/%0d/%0d/%0d %b%b exp=%0d/%0d/%0d/%0d/%0d %b%b",
               idx, c_mp, c_tp, c_ml, c_tl, c_bp, mode_level, trip_level,
               p.mp, p.tp, p.ml, p.tl, p.bp, p.lm, p.lt);
    end
  endtask

  initial begin
    // 1: Mode short press
    tbl.push_back(ph(0,1,10, 0,0,0,0,0, 1,0));
    tbl.push_back(ph(1,1,20, 1,0,0,0,0, 0,0));
    // 2: Trip glitches shorter than the debounce window
    for (int g = 0; g < 5; g++) begin
      tbl.push_back(ph(1,0,3, 0,0,0,0,0, 0,0));
      tbl.push_back(ph(1,1,2, 0,0,0,0,0, 0,0));
    end
    tbl.push_back(ph(1,1,10, 0,0,0,0,0, 0,0));
    // 3: Trip long hold, silent release
    tbl.push_back(ph(1,0,40, 0,0,0,1,0, 0,1));
    tbl.push_back(ph(1,1,20, 0,0,0,0,0, 0,0));
    // 4: chord, released apart
    tbl.push_back(ph(0,0,30, 0,0,0,0,1, 1,1));
    tbl.push_back(ph(1,0,10, 0,0,0,0,0, 0,1));
    tbl.push_back(ph(1,1,20, 0,0,0,0,0, 0,0));
    // 5: staggered overlap too short for a chord
    tbl.push_back(ph(0,1,2,  0,0,0,0,0, 0,0));
    tbl.push_back(ph(0,0,5,  0,0,0,0,0, 1,0));
    tbl.push_back(ph(1,1,20, 1,1,0,0,0, 0,0));
    // simultaneous release without chord
    tbl.push_back(ph(0,0,6,  0,0,0,0,0, 1,1));
    tbl.push_back(ph(1,1,20, 1,1,0,0,0, 0,0));

    HRESETn = 1'b0; nMode = 1'b1; nTrip = 1'b1;
    model_reset();
    repeat (2) @(negedge HCLK);
    check_out();
    HRESETn = 1'b1;

    foreach (tbl[i]) run_phase(i, tbl[i]);

    // 6: reset while Mode is HELD, pin already released when reset lifts
    for (int k = 0; k < 8; k++) step(0, 1);
    HRESETn = 1'b0; nMode = 1'b1;
    model_reset();
    #2 check_out();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    run_phase(99, ph(1,1,20, 0,0,0,0,0, 0,0));

    // Randomised runs against the model
    begin
      bit pin[2];
      int left[2];
      pin[0] = 1; pin[1] = 1; left[0] = 0; left[1] = 0;
      for (int k = 0; k < 3000; k++) begin
        for (int b = 0; b < 2; b++) begin
          if (left[b] == 0) begin
            pin[b] = ~pin[b];
            left[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 45);
          end
          left[b]--;
        end
        step(pin[0], pin[1]);
      end
      for (int k = 0; k < 40; k++) step(1, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
